// File: rtl/dbg_print_arb.sv
// Round-robin arbiter that prints one requester value per message as "<id>:0x<hex>[\n]"; DBG_PRINT_TS_EN adds a "t=<ts> " prefix.
// First char 1 cycle after accept; out_valid/out_char hold until out_ready, and requests wait (req_ready=0) while busy.
module dbg_print_arb #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int TS_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_nl,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [7:0]                out_char,
   output logic                      busy
);

   localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HN   = DATA_W / 4;
   localparam int TN   = TS_W / 4;
   localparam int MAXC = (TN + 3 > HN) ? TN + 3 : HN;
   localparam int IW   = $clog2(MAXC + 1);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ID   = 3'd2;
   localparam logic [2:0] ST_PFX  = 3'd3;
   localparam logic [2:0] ST_HEX  = 3'd4;
   localparam logic [2:0] ST_NL   = 3'd5;
`ifdef DBG_PRINT_TS_EN
   localparam logic [2:0] ST_TS   = 3'd1;
`endif

   typedef struct packed {
      logic [DATA_W-1:0] dat;
      logic              nl;
      logic [IDW-1:0]    id;
   } msg_t;

   msg_t           msg;
   logic [2:0]     state, nxt;
   logic [IW-1:0]  idx;
   logic [IDW-1:0] ptr, win;
   logic           found, last;
   logic [NUM_REQ-1:0] grant;
`ifdef DBG_PRINT_TS_EN
   logic [TS_W-1:0] ts_cnt, ts_cap;
`endif

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : 8'h57 + {4'h0, n};
   endfunction

   // Search starts at ptr and wraps; first valid requester wins.
   always_comb begin : arb
      int j;
      j     = 0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_valid[j]) begin
            found = 1'b1;
            win   = IDW'(j);
         end
      end
      grant     = found ? (NUM_REQ'(1) << win) : '0;
      req_ready = (rst_n && state == ST_IDLE) ? grant : '0;
   end

   assign out_valid = (state != ST_IDLE);
   assign busy      = out_valid | (|req_ready);

   always_comb begin : fmt
      out_char = 8'h00;
      case (state)
`ifdef DBG_PRINT_TS_EN
         ST_TS: begin
            if (idx == IW'(0))           out_char = 8'h74;
            else if (idx == IW'(1))      out_char = 8'h3d;
            else if (idx == IW'(TN + 2)) out_char = 8'h20;
            else begin
               for (int d = 0; d < TN; d++)
                  if (idx == IW'(d + 2)) out_char = hexc(ts_cap[4*(TN-1-d) +: 4]);
            end
         end
`endif
         ST_ID:  out_char = (idx == '0) ? hexc(4'(msg.id)) : 8'h3a;
         ST_PFX: out_char = (idx == '0) ? 8'h30 : 8'h78;
         ST_HEX: begin
            for (int d = 0; d < HN; d++)
               if (idx == IW'(d)) out_char = hexc(msg.dat[4*(HN-1-d) +: 4]);
         end
         ST_NL:  out_char = 8'h0a;
         default: out_char = 8'h00;
      endcase
   end

   always_comb begin : seq
      last = 1'b0;
      nxt  = ST_IDLE;
      case (state)
`ifdef DBG_PRINT_TS_EN
         ST_TS:  begin last = (idx == IW'(TN + 2)); nxt = ST_ID; end
`endif
         ST_ID:  begin last = (idx == IW'(1)); nxt = ST_PFX; end
         ST_PFX: begin last = (idx == IW'(1)); nxt = ST_HEX; end
         ST_HEX: begin last = (idx == IW'(HN - 1)); nxt = msg.nl ? ST_NL : ST_IDLE; end
         ST_NL:  begin last = 1'b1; nxt = ST_IDLE; end
         default: begin last = 1'b0; nxt = ST_IDLE; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         ptr   <= '0;
         msg   <= '0;
`ifdef DBG_PRINT_TS_EN
         ts_cnt <= '0;
         ts_cap <= '0;
`endif
      end else begin
`ifdef DBG_PRINT_TS_EN
         ts_cnt <= ts_cnt + 1'b1;
`endif
         if (state == ST_IDLE) begin
            if (found) begin
               msg.dat <= req_data[win*DATA_W +: DATA_W];
               msg.nl  <= req_nl[win];
               msg.id  <= win;
               ptr     <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
               idx     <= '0;
`ifdef DBG_PRINT_TS_EN
               ts_cap  <= ts_cnt;
               state   <= ST_TS;
`else
               state   <= ST_ID;
`endif
            end
         end else if (out_ready) begin
            if (last) begin
               idx   <= '0;
               state <= nxt;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_dbg_print_arb.sv
// Randomised bench for dbg_print_arb: expected text comes from $sformatf over the requester's value.
module tb_dbg_print_arb;
   localparam int NR = 4;
   localparam int DW = 32;
   localparam int TW = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid, req_ready, req_nl;
   logic [NR*DW-1:0] req_data;
   logic             out_valid, out_ready, busy;
   logic [7:0]       out_char;
   logic [TW-1:0]    tb_ts;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) tb_ts <= rst_n ? tb_ts + 1'b1 : '0;

   dbg_print_arb #(.NUM_REQ(NR), .DATA_W(DW), .TS_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_nl(req_nl), .out_valid(out_valid),
      .out_ready(out_ready), .out_char(out_char), .busy(busy)
   );

   function automatic string fmt(input int id, input logic [31:0] d, input logic nl, input logic [TW-1:0] ts);
      string s;
      s = $sformatf("%h:0x%h", 4'(id), d);
`ifdef DBG_PRINT_TS_EN
      s = {$sformatf("t=%h ", ts), s};
`endif
      if (nl) s = {s, "\n"};
      return s;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int id, input logic [31:0] d, input logic nl,
                        output logic [TW-1:0] ts, output bit ok);
      req_valid[id] = 1'b1;
      req_data[id*DW +: DW] = d;
      req_nl[id] = nl;
      ok = 1'b0;
      ts = '0;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         if (req_ready[id]) begin ok = 1'b1; ts = tb_ts; end
         cyc();
      end
      req_valid[id] = 1'b0;
      req_data[id*DW +: DW] = $urandom;
      req_nl[id] = 1'($urandom_range(0, 1));
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL grant_timeout id=%0d: no req_ready within 300 cycles", id);
      end
   endtask

   task automatic collect(input int n, input int pct, output string s);
      s = "";
      for (int c = 0; c < 2000 && s.len() < n; c++) begin
         out_ready = ($urandom_range(0, 99) < pct);
         @(negedge clk);
         if (out_valid && out_ready) s = $sformatf("%s%c", s, out_char);
         cyc();
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = '1; req_data = {$urandom, $urandom, $urandom, $urandom};
      req_nl = '0; out_ready = 1'b1;
      repeat (3) cyc();
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (out_char !== 8'h00) begin bad++; $display("FAIL rst_out_char got=%h want=00", out_char); end
      total++; if (req_ready !== '0) begin bad++; $display("FAIL rst_req_ready got=%b want=0000", req_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      cyc();
      req_valid = '0;
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      logic [TW-1:0] ts;
      string exp;
      bit ok;
      req_valid[0] = 1'b1; req_data[0 +: DW] = 32'h0000002D; req_nl[0] = 1'b1;
      ok = 1'b0; ts = '0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            ok = 1'b1; ts = tb_ts;
            total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", req_ready); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_accept got=%b want=1", busy); end
         end
         cyc();
      end
      req_valid[0] = 1'b0;
      exp = fmt(0, 32'h0000002D, 1'b1, ts);
      for (int c = 0; c < exp.len(); c++) begin
         @(negedge clk);
         total++;
         if (out_valid !== 1'b1 || out_char !== exp[c]) begin
            bad++; $display("FAIL single_char%0d got vld=%b chr=%h want vld=1 chr=%h", c, out_valid, out_char, exp[c]);
         end
         cyc();
      end
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL single_end got vld=%b busy=%b want 0 0", out_valid, busy);
      end
      cyc();
   endtask

   task automatic test_write();
      logic [TW-1:0] ts;
      string exp, got;
      bit ok;
      issue(3, 32'h000000A4, 1'b0, ts, ok);
      exp = fmt(3, 32'h000000A4, 1'b0, ts);
      collect(exp.len(), 100, got);
      total++; if (got != exp) begin bad++; $display("FAIL write_text got=\"%s\" want=\"%s\"", got, exp); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL write_no_nl got vld=%b chr=%h want vld=0", out_valid, out_char); end
      cyc();
   endtask

   task automatic test_rr();
      logic [31:0] dat [NR] = '{32'h0A0B0C0D, 32'h11111111, 32'h22222222, 32'h33333333};
      int want [6] = '{1, 2, 1, 2, 0, 1};
      int grants[$];
      logic [TW-1:0] tsq[$];
      string got, rest, exp;
      int oh_bad = 0;
      int need;
      for (int i = 0; i < NR; i++) begin req_data[i*DW +: DW] = dat[i]; end
      req_nl = '0; out_ready = 1'b1; got = "";
      req_valid = 4'b0110;
      for (int c = 0; c < 400 && grants.size() < 6; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            if ($countones(req_ready) != 1) oh_bad++;
            for (int i = 0; i < NR; i++) if (req_ready[i]) grants.push_back(i);
            tsq.push_back(tb_ts);
         end
         if (out_valid && out_ready) got = $sformatf("%s%c", got, out_char);
         cyc();
         if (grants.size() == 3) req_valid[0] = 1'b1;
      end
      req_valid = '0;
      exp = "";
      for (int i = 0; i < grants.size(); i++) exp = {exp, fmt(want[i], dat[want[i]], 1'b0, tsq[i])};
      need = exp.len() - got.len();
      collect(need, 100, rest);
      got = {got, rest};
      total++; if (grants.size() != 6) begin bad++; $display("FAIL rr_count got=%0d want=6", grants.size()); end
      for (int i = 0; i < grants.size(); i++) begin
         total++; if (grants[i] != want[i]) begin bad++; $display("FAIL rr_grant%0d got=%0d want=%0d", i, grants[i], want[i]); end
      end
      total++; if (oh_bad != 0) begin bad++; $display("FAIL rr_onehot got=%0d violations want=0", oh_bad); end
      total++; if (got != exp) begin bad++; $display("FAIL rr_text got=\"%s\" want=\"%s\"", got, exp); end
   endtask

   task automatic test_backpressure();
      logic [TW-1:0] ts;
      string exp, got;
      bit ok;
      int k = 0;
      int hold = 0;
      issue(2, 32'h1234ABCD, 1'b1, ts, ok);
      exp = fmt(2, 32'h1234ABCD, 1'b1, ts);
      got = "";
      for (int c = 0; c < 200 && k < exp.len(); c++) begin
         out_ready = !(k == 6 && hold < 5);
         @(negedge clk);
         if (!out_ready) begin
            hold++;
            total++;
            if (out_valid !== 1'b1 || out_char !== exp[6]) begin
               bad++; $display("FAIL bp_hold%0d got vld=%b chr=%h want vld=1 chr=%h", hold, out_valid, out_char, exp[6]);
            end
         end else if (out_valid) begin
            got = $sformatf("%s%c", got, out_char);
            k++;
         end
         cyc();
      end
      out_ready = 1'b1;
      total++; if (hold != 5) begin bad++; $display("FAIL bp_stall_cycles got=%0d want=5", hold); end
      total++; if (got != exp) begin bad++; $display("FAIL bp_text got=\"%s\" want=\"%s\"", got, exp); end
   endtask

   task automatic test_reset_mid();
      logic [TW-1:0] ts;
      string exp, got;
      logic [NR-1:0] g;
      bit ok;
      issue(1, 32'hDEADBEEF, 1'b1, ts, ok);
      exp = fmt(1, 32'hDEADBEEF, 1'b1, ts);
      collect(exp.len() - 11, 100, got);
      rst_n = 1'b0;
      req_valid = 4'b0110;
      req_data[1*DW +: DW] = 32'h00005EED;
      req_data[2*DW +: DW] = 32'h00000BAD;
      req_nl = 4'b0000;
      cyc();
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || out_char !== 8'h00) begin
         bad++; $display("FAIL midrst_out got vld=%b chr=%h want vld=0 chr=00", out_valid, out_char);
      end
      total++; if (req_ready !== '0 || busy !== 1'b0) begin
         bad++; $display("FAIL midrst_ready got rdy=%b busy=%b want 0000 0", req_ready, busy);
      end
      cyc();
      rst_n = 1'b1;
      ok = 1'b0; g = '0;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin ok = 1'b1; g = req_ready; ts = tb_ts; end
         cyc();
      end
      req_valid = '0;
      total++; if (g !== 4'b0010) begin bad++; $display("FAIL midrst_ptr got=%b want=0010", g); end
      exp = fmt(1, 32'h00005EED, 1'b0, ts);
      collect(exp.len(), 100, got);
      total++; if (got != exp) begin bad++; $display("FAIL midrst_text got=\"%s\" want=\"%s\"", got, exp); end
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_resume got vld=%b want=0", out_valid); end
      cyc();
   endtask

   task automatic test_back_to_back();
      int gcyc[$];
      logic [TW-1:0] tsq[$];
      string got, exp;
      int len1, len2;
      len1 = fmt(0, 32'h00C0FFEE, 1'b1, '0).len();
      len2 = fmt(0, 32'h00000007, 1'b0, '0).len();
      out_ready = 1'b1; got = "";
      req_valid[0] = 1'b1; req_data[0 +: DW] = 32'h00C0FFEE; req_nl[0] = 1'b1;
      for (int c = 0; c < 200 && got.len() < len1 + len2; c++) begin
         @(negedge clk);
         if (req_ready[0]) begin gcyc.push_back(c); tsq.push_back(tb_ts); end
         if (out_valid && out_ready) got = $sformatf("%s%c", got, out_char);
         cyc();
         if (gcyc.size() == 1) begin req_data[0 +: DW] = 32'h00000007; req_nl[0] = 1'b0; end
         if (gcyc.size() == 2) req_valid[0] = 1'b0;
      end
      req_valid[0] = 1'b0;
      total++;
      if (gcyc.size() != 2) begin
         bad++; $display("FAIL b2b_grants got=%0d want=2", gcyc.size());
      end else begin
         total++; if (gcyc[1] - gcyc[0] != len1 + 1) begin
            bad++; $display("FAIL b2b_gap got=%0d want=%0d", gcyc[1] - gcyc[0], len1 + 1);
         end
         exp = {fmt(0, 32'h00C0FFEE, 1'b1, tsq[0]), fmt(0, 32'h00000007, 1'b0, tsq[1])};
         total++; if (got != exp) begin bad++; $display("FAIL b2b_text got=\"%s\" want=\"%s\"", got, exp); end
      end
   endtask

   task automatic test_random();
      logic [TW-1:0] ts;
      logic [31:0] d;
      logic nl;
      int id;
      string exp, got;
      bit ok;
      for (int n = 0; n < 30; n++) begin
         id = $urandom_range(0, NR - 1);
         d  = $urandom;
         nl = 1'($urandom_range(0, 1));
         issue(id, d, nl, ts, ok);
         exp = fmt(id, d, nl, ts);
         collect(exp.len(), 60, got);
         total++; if (got != exp) begin bad++; $display("FAIL rand%0d_text got=\"%s\" want=\"%s\"", n, got, exp); end
         repeat ($urandom_range(0, 2)) cyc();
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; req_data = '0; req_nl = '0; out_ready = 1'b1;
      test_reset();
      test_single();
      test_write();
      test_rr();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
